// File: rtl/bf_io_uart_pkg.sv
// Shared definitions for the Brainfuck CPU I/O UART bridge: handshake states,
// direction encodings and receiver states.
package bf_io_uart_pkg;

  typedef enum logic [1:0] {
    BFIO_IDLE,
    BFIO_RD_WAIT,
    BFIO_WR_WAIT,
    BFIO_ACK_HOLD
  } bfio_state_e;

  localparam logic DIRECTION_READ  = 1'b0;
  localparam logic DIRECTION_WRITE = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/bf_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; the head entry is read straight
// from the storage registers.
module bf_sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wptr_q;
  logic [DEPTH_LOG2:0] rptr_q;
  logic                do_push;
  logic                do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                   (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/bf_io_uart.sv
// Bridges the CPU req/ack I/O port to an 8N1 UART: '.' writes become TX
// frames, ',' reads are served from a FIFO of received bytes.
module bf_io_uart
  import bf_io_uart_pkg::*;
#(
  parameter logic [15:0] CLK_DIV            = 16'd868,
  parameter int unsigned RX_FIFO_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_req,
  input  logic       io_dir,
  input  logic [7:0] io_wdata,
  output logic       io_ack,
  output logic [7:0] io_rdata,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam logic [15:0] BIT_M1  = CLK_DIV - 16'd1;
  localparam logic [15:0] HALF_M1 = (CLK_DIV >> 1) - 16'd1;

  bfio_state_e state_q;
  logic        io_ack_q;
  logic [7:0]  io_rdata_q;

  logic        tx_busy_q;
  logic [15:0] tx_cnt_q;
  logic [3:0]  tx_bit_q;
  logic [8:0]  tx_shift_q;
  logic        uart_tx_q;

  rx_state_e   rx_state_q;
  logic        rx_meta_q;
  logic        rx_sync_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;
  logic        rx_push_q;
  logic [7:0]  rx_byte_q;
  logic        overrun_q;
  logic        frame_err_q;

  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        tx_start;

  assign fifo_pop = (state_q == BFIO_RD_WAIT) && io_req && !fifo_empty;
  assign tx_start = (state_q == BFIO_WR_WAIT) && io_req && !tx_busy_q;

  bf_sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (RX_FIFO_DEPTH_LOG2)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_push_q),
    .wdata_i (rx_byte_q),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A request dropped while waiting is a protocol violation: abandon silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BFIO_IDLE;
      io_ack_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      case (state_q)
        BFIO_IDLE: begin
          if (io_req) state_q <= (io_dir == DIRECTION_WRITE) ? BFIO_WR_WAIT : BFIO_RD_WAIT;
        end
        BFIO_RD_WAIT: begin
          if (!io_req) begin
            state_q <= BFIO_IDLE;
          end else if (!fifo_empty) begin
            io_rdata_q <= fifo_rdata;
            io_ack_q   <= 1'b1;
            state_q    <= BFIO_ACK_HOLD;
          end
        end
        BFIO_WR_WAIT: begin
          if (!io_req) begin
            state_q <= BFIO_IDLE;
          end else if (!tx_busy_q) begin
            io_ack_q <= 1'b1;
            state_q  <= BFIO_ACK_HOLD;
          end
        end
        BFIO_ACK_HOLD: begin
          if (!io_req) begin
            io_ack_q <= 1'b0;
            state_q  <= BFIO_IDLE;
          end
        end
        default: state_q <= BFIO_IDLE;
      endcase
    end
  end

  // Bit 0 is the start bit; bits 1..9 shift out {stop, data} LSB first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_busy_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
      uart_tx_q  <= 1'b1;
    end else if (tx_start) begin
      tx_shift_q <= {1'b1, io_wdata};
      uart_tx_q  <= 1'b0;
      tx_busy_q  <= 1'b1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == BIT_M1) begin
        tx_cnt_q <= '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
          uart_tx_q <= 1'b1;
        end else begin
          tx_bit_q   <= tx_bit_q + 4'd1;
          uart_tx_q  <= tx_shift_q[0];
          tx_shift_q <= {1'b1, tx_shift_q[8:1]};
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_push_q   <= 1'b0;
      rx_byte_q   <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_push_q <= 1'b0;
      if (rx_push_q && fifo_full) overrun_q <= 1'b1;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_sync_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF_M1) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_M1) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BIT_M1) begin
            rx_cnt_q <= '0;
            if (rx_sync_q) begin
              rx_push_q  <= 1'b1;
              rx_byte_q  <= rx_shift_q;
              rx_state_q <= RX_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              rx_state_q  <= RX_WAIT_HIGH;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync_q) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign io_ack       = io_ack_q;
  assign io_rdata     = io_rdata_q;
  assign uart_tx      = uart_tx_q;
  assign rx_overrun   = overrun_q;
  assign rx_frame_err = frame_err_q;

endmodule

// File: doc/bf_io_uart.md
Name: bf_io_uart

Overview:
- Sits directly downstream of the Brainfuck CPU's I/O port (io_req/io_dir/io_wdata/io_ack/io_rdata).
- Turns '.' writes into 8N1 UART transmit frames; serves ',' reads from a received-byte FIFO.
- Stalls the CPU through the four-phase req/ack handshake until the operation can complete.

Parameters:
- CLK_DIV, 16'd868, clock cycles per UART bit (>= 4); 868 = 100 MHz / 115200.
- RX_FIFO_DEPTH_LOG2, 4, log2 of RX FIFO depth (16 entries).

Ports:
- clk  in  1  clock; all logic posedge.
- rst_n  in  1  synchronous, active-low reset.
- io_req  in  1  CPU request; held high until io_ack seen, then dropped.
- io_dir  in  1  0 = read (','), 1 = write ('.'); shared direction macros.
- io_wdata  in  8  byte to transmit; valid while io_req=1 and io_dir=1.
- io_ack  out  1  completion acknowledge.
- io_rdata  out  8  received byte; stable while io_ack=1.
- uart_tx  out  1  serial output, idle high.
- uart_rx  in  1  serial input, asynchronous.
- rx_overrun  out  1  sticky: a received byte was dropped because the FIFO was full.
- rx_frame_err  out  1  sticky: a received frame had a bad stop bit.

Behaviour:
- Reset values:
  - io_ack=0, io_rdata=0, uart_tx=1, rx_overrun=0, rx_frame_err=0.
  - FIFO emptied; TX and RX idle; handshake FSM in IDLE.
- Handshake FSM (IDLE, RD_WAIT, WR_WAIT, ACK_HOLD), all registered:
  - IDLE:
    - io_req=1, io_dir=0 -> RD_WAIT.
    - io_req=1, io_dir=1 -> WR_WAIT.
  - RD_WAIT:
    - FIFO non-empty: io_rdata<=FIFO head, pop, io_ack<=1 -> ACK_HOLD.
    - FIFO empty: wait indefinitely.
  - WR_WAIT:
    - TX idle: latch io_wdata into TX shift register, start frame, io_ack<=1 -> ACK_HOLD.
    - TX busy: wait.
  - ACK_HOLD:
    - Hold io_ack=1 and io_rdata while io_req=1.
    - First cycle io_req sampled 0: io_ack<=0 -> IDLE.
- Latency:
  - Minimum req-rise to ack-rise is 2 clk (1 to enter the WAIT state, 1 to assert io_ack).
  - Write ack means the byte is accepted, not that it is fully shifted out.
- TX:
  - Frame is start(0), 8 data bits LSB first, stop(1); each bit lasts CLK_DIV cycles.
  - Frame length is exactly 10*CLK_DIV cycles, after which TX is idle.
  - A second write waits in WR_WAIT until the previous frame's stop bit has completed.
- RX:
  - uart_rx passes through a 2-FF synchronizer.
  - Start is detected when the synchronised line is 0 while RX is idle.
  - Re-check at CLK_DIV/2: if the line is 1, it was a glitch -> return to idle.
  - Sample 8 data bits at mid-bit, then the stop bit.
  - Stop bit = 1: push byte into FIFO.
  - Stop bit = 0: discard byte, set rx_frame_err, wait for line high before re-arming.
- FIFO:
  - 2^RX_FIFO_DEPTH_LOG2 entries; pointers one bit wider than the address to distinguish full from empty.
  - Pointers wrap modulo 2*depth.
  - Push when full: byte dropped, rx_overrun<=1.
  - Push and pop in the same cycle: both occur, count unchanged; when empty, pop is not possible that cycle.
- Sticky flags clear only on reset.
- Reset mid-operation:
  - Aborts the TX frame; uart_tx=1 the next cycle.
  - Discards the partial RX byte; io_ack drops next cycle.
- io_req falling while in RD_WAIT or WR_WAIT is a protocol violation; the FSM returns to IDLE with no side effect.

Decomposition:
- Shared header (macros directory):
  - handshake FSM state encodings (BFIO_IDLE, BFIO_RD_WAIT, BFIO_WR_WAIT, BFIO_ACK_HOLD).
  - DIRECTION_READ=0, DIRECTION_WRITE=1.
- One sub-module: bf_sync_fifo (parameterised width/depth, push/pop/full/empty, registered head output), instantiated for RX.
- TX/RX serialisers live inline in bf_io_uart.

Test Plan (CLK_DIV=4, RX_FIFO_DEPTH_LOG2=2):
- Write 8'h41 with TX idle -> io_ack rises 2 clk after io_req; uart_tx shows 0,1,0,0,0,0,0,1,0,1 at 4 clk per bit.
- Write 8'h42 while 8'h41 is still shifting -> io_ack is withheld until the frame ends (40 clk after the first start bit); then 8'h42 frame starts.
- Read with FIFO empty, then drive frame 8'h5A on uart_rx -> io_ack rises after the stop-bit sample; io_rdata=8'h5A held until io_req drops; FIFO ends empty.
- Drive 5 frames (8'h01..8'h05) with no reads -> rx_overrun=1; four reads return 01,02,03,04.
- Frame with stop bit 0 -> rx_frame_err=1, nothing pushed; a following valid frame 8'h33 is received correctly.
- Assert rst_n=0 mid TX frame and mid handshake -> next cycle uart_tx=1, io_ack=0, FIFO empty, flags 0.
